// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: default geometry, RGB888 field positions,
// luma weights and the loader FSM state encoding.
package img_pkg;

  localparam int IMG_WIDTH_DEF  = 32;
  localparam int IMG_HEIGHT_DEF = 32;

  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int W_R_DEF    = 77;
  localparam int W_G_DEF    = 150;
  localparam int W_B_DEF    = 29;
  localparam int LUMA_SHIFT = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rgb2gray_pix.sv
// Two-stage luma unit: S1 registers the weighted channels, S2 registers the
// shifted sum. Outputs hold their last value once the pipeline empties.
module rgb2gray_pix
  import img_pkg::*;
#(
  parameter int IDX_W = 10,
  parameter int W_R   = W_R_DEF,
  parameter int W_G   = W_G_DEF,
  parameter int W_B   = W_B_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [23:0]      rgb_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [7:0]       gray_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             busy_o
);

  logic             s1Valid_q;
  logic [IDX_W-1:0] s1Idx_q;
  logic [15:0]      pR_q, pG_q, pB_q;
  logic [15:0]      pR_d, pG_d, pB_d;

  logic             s2Valid_q;
  logic [IDX_W-1:0] s2Idx_q;
  logic [7:0]       gray_q;
  logic [15:0]      sum_d;
  logic [7:0]       gray_d;

  always_comb begin
    pR_d = 16'(rgb_i[R_LSB +: CH_W]) * 16'(W_R);
    pG_d = 16'(rgb_i[G_LSB +: CH_W]) * 16'(W_G);
    pB_d = 16'(rgb_i[B_LSB +: CH_W]) * 16'(W_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Idx_q   <= '0;
      pR_q      <= '0;
      pG_q      <= '0;
      pB_q      <= '0;
    end else begin
      s1Valid_q <= valid_i;
      if (valid_i) begin
        s1Idx_q <= idx_i;
        pR_q    <= pR_d;
        pG_q    <= pG_d;
        pB_q    <= pB_d;
      end
    end
  end

  // Weights sum to 256, so the 16-bit sum cannot overflow and gray never exceeds 255.
  always_comb begin
    sum_d  = pR_q + pG_q + pB_q;
    gray_d = 8'(sum_d >> LUMA_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      s2Idx_q   <= '0;
      gray_q    <= '0;
    end else begin
      s2Valid_q <= s1Valid_q;
      if (s1Valid_q) begin
        s2Idx_q <= s1Idx_q;
        gray_q  <= gray_d;
      end
    end
  end

  assign valid_o = s2Valid_q;
  assign gray_o  = gray_q;
  assign idx_o   = s2Idx_q;
  assign busy_o  = s1Valid_q;

endmodule

// File: rtl/rgb2gray_loader.sv
// Streams an RGB888 image out of a source BRAM, converts each pixel to luma and
// writes it to BRAM0 one word per pixel; start/done handshake with the conv stage.
module rgb2gray_loader
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int W_R        = W_R_DEF,
  parameter int W_G        = W_G_DEF,
  parameter int W_B        = W_B_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [31:0] src_addr,
  output logic        src_en,
  input  logic [31:0] src_dout,
  output logic [31:0] bram0_addr,
  output logic [31:0] bram0_din,
  output logic [3:0]  bram0_we
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  if (W_R + W_G + W_B != 256) begin : gWeightCheck
    $error("rgb2gray_loader: luma weights must sum to 256");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rdValid_q;
  logic [IDX_W-1:0] rdIdx_q;

  logic             pixValid;
  logic [7:0]       pixGray;
  logic [IDX_W-1:0] pixIdx;
  logic             pixBusy;
  logic             unusedTopByte;

  assign unusedTopByte = ^src_dout[31:24];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      // Leave DRAIN while the final write is on the BRAM0 port, so done follows it directly.
      ST_DRAIN: begin
        if (!rdValid_q && !pixBusy) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      rdValid_q <= 1'b0;
      rdIdx_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rdValid_q <= (state_q == ST_RUN);
      rdIdx_q   <= idx_q;
    end
  end

  assign src_en   = (state_q == ST_RUN);
  assign src_addr = src_en ? 32'({idx_q, 2'b00}) : 32'd0;
  assign done     = (state_q == ST_DONE);

  rgb2gray_pix #(
    .IDX_W (IDX_W),
    .W_R   (W_R),
    .W_G   (W_G),
    .W_B   (W_B)
  ) uPix (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rdValid_q),
    .rgb_i   (src_dout[23:0]),
    .idx_i   (rdIdx_q),
    .valid_o (pixValid),
    .gray_o  (pixGray),
    .idx_o   (pixIdx),
    .busy_o  (pixBusy)
  );

  assign bram0_we   = pixValid ? 4'b1111 : 4'b0000;
  assign bram0_addr = 32'({pixIdx, 2'b00});
  assign bram0_din  = {24'd0, pixGray};

endmodule

// File: tb/tb_rgb2gray_loader.sv
// Bench for rgb2gray_loader on a 4x4 image with a 1-cycle-latency source BRAM model;
// captures every BRAM0 write and compares it against a plain-arithmetic luma model.
module tb_rgb2gray_loader;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        done;
  logic [31:0] src_addr;
  logic        src_en;
  logic [31:0] src_dout;
  logic [31:0] bram0_addr;
  logic [31:0] bram0_din;
  logic [3:0]  bram0_we;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  gray;
  } vec_t;

  logic [31:0] srcMem [N];
  wr_t         wrQ [$];
  vec_t        vecs [8];
  int          cyc = 0;
  int          nChecks = 0;
  int          nPass = 0;

  rgb2gray_loader #(
    .IMG_WIDTH  (4),
    .IMG_HEIGHT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .done       (done),
    .src_addr   (src_addr),
    .src_en     (src_en),
    .src_dout   (src_dout),
    .bram0_addr (bram0_addr),
    .bram0_din  (bram0_din),
    .bram0_we   (bram0_we)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (src_en) src_dout <= srcMem[src_addr[5:2]];
  end

  always @(negedge clk) begin
    if (bram0_we != 4'b0000) wrQ.push_back('{cyc: cyc, addr: bram0_addr, din: bram0_din, we: bram0_we});
  end

  function automatic int lumaRef(input logic [31:0] w);
    int r, g, b;
    r = int'(w[23:16]);
    g = int'(w[15:8]);
    b = int'(w[7:0]);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_src_en"}, 32'(src_en), 32'd0);
    checkOutput({tag, "_src_addr"}, src_addr, 32'd0);
    checkOutput({tag, "_bram0_addr"}, bram0_addr, 32'd0);
    checkOutput({tag, "_bram0_din"}, bram0_din, 32'd0);
    checkOutput({tag, "_bram0_we"}, 32'(bram0_we), 32'd0);
  endtask

  // mode 0: one-cycle start pulse, 1: start held high, 2: start toggled during RUN/DRAIN
  task automatic applyStimulus(input int mode, input string tag);
    int c0;
    int doneCyc;
    int n;
    wrQ.delete();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    doneCyc = -1;
    for (int i = 1; i <= 200 && doneCyc < 0; i++) begin
      @(negedge clk);
      if (done) doneCyc = cyc;
      if (mode == 0) start = 1'b0;
      if (mode == 2) start = (cyc <= c0 + N + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    checkOutput({tag, "_done_cycle"}, 32'(doneCyc - c0), 32'(N + 4));
    checkOutput({tag, "_write_count"}, 32'(wrQ.size()), 32'(N));
    n = (wrQ.size() < N) ? wrQ.size() : N;
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s_wr%0d_cycle", tag, k), 32'(wrQ[k].cyc - c0), 32'(k + 4));
      checkOutput($sformatf("%s_wr%0d_addr", tag, k), wrQ[k].addr, 32'(k * 4));
      checkOutput($sformatf("%s_wr%0d_din", tag, k), wrQ[k].din, 32'(lumaRef(srcMem[k])));
      checkOutput($sformatf("%s_wr%0d_we", tag, k), 32'(wrQ[k].we), 32'hF);
    end
    if (mode != 1) begin
      @(negedge clk);
      checkOutput({tag, "_done_fall"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int c0;

    vecs[0] = '{word: 32'h00FF0000, gray: 8'd76};
    vecs[1] = '{word: 32'h0000FF00, gray: 8'd149};
    vecs[2] = '{word: 32'h000000FF, gray: 8'd28};
    vecs[3] = '{word: 32'hAB000000, gray: 8'd0};
    vecs[4] = '{word: 32'h00FFFFFF, gray: 8'd255};
    vecs[5] = '{word: 32'h00000000, gray: 8'd0};
    vecs[6] = '{word: 32'h00808080, gray: 8'd128};
    vecs[7] = '{word: 32'hFF010101, gray: 8'd1};

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] all-white image");
    for (int k = 0; k < N; k++) srcMem[k] = 32'h00FFFFFF;
    applyStimulus(0, "white");
    for (int k = 0; k < N && k < wrQ.size(); k++)
      checkOutput($sformatf("white_gray%0d", k), wrQ[k].din, 32'h000000FF);

    $display("[TB] table vectors");
    for (int k = 0; k < N; k++) srcMem[k] = vecs[k % 8].word;
    applyStimulus(0, "table");
    for (int k = 0; k < N && k < wrQ.size(); k++)
      checkOutput($sformatf("table_gray%0d", k), wrQ[k].din, {24'd0, vecs[k % 8].gray});

    $display("[TB] start held high through DONE");
    for (int k = 0; k < N; k++) srcMem[k] = $urandom;
    applyStimulus(1, "hold");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_done%0d", i), 32'(done), 32'd1);
    end
    checkOutput("hold_no_second_pass", 32'(wrQ.size()), 32'(N));
    start = 1'b0;
    @(negedge clk);
    checkOutput("hold_done_fall", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("hold_idle_src_en", 32'(src_en), 32'd0);

    $display("[TB] start toggled mid-pass");
    for (int k = 0; k < N; k++) srcMem[k] = $urandom;
    applyStimulus(2, "toggle");

    $display("[TB] reset during RUN");
    for (int k = 0; k < N; k++) srcMem[k] = $urandom;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("abort_src_addr_idx7", src_addr, 32'd28);
    checkOutput("abort_src_en", 32'(src_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("abort");
    wrQ.delete();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("abort_no_writes", 32'(wrQ.size()), 32'd0);
    checkOutput("abort_done_low", 32'(done), 32'd0);
    applyStimulus(0, "after_abort");

    $display("[TB] ramp image");
    for (int k = 0; k < N; k++) srcMem[k] = {8'h00, 8'(k), 8'(2 * k), 8'(3 * k)};
    applyStimulus(0, "ramp");
    for (int k = 0; k < N && k < wrQ.size(); k++)
      checkOutput($sformatf("ramp_gray%0d", k), wrQ[k].din, 32'((464 * k) / 256));

    $display("[TB] random images");
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < N; k++) srcMem[k] = $urandom;
      applyStimulus(0, $sformatf("rand%0d", p));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
